// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the byte-wide trace register bus: master 0 has priority,
// master 1 is protected by a starvation counter, read data follows its issuer.
module reg_bus_arbiter #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1,
  parameter int pMAX_WAIT     = 64
) (
  input  logic                     usb_clk,
  input  logic                     reset_i,
  input  logic                     m0_req,
  input  logic [7:0]               m0_address,
  input  logic [pBYTECNT_SIZE-1:0] m0_bytecnt,
  input  logic [7:0]               m0_write_data,
  input  logic                     m0_read,
  input  logic                     m0_write,
  output logic                     m0_gnt,
  output logic [7:0]               m0_read_data,
  output logic                     m0_rdvalid,
  input  logic                     m1_req,
  input  logic [7:0]               m1_address,
  input  logic [pBYTECNT_SIZE-1:0] m1_bytecnt,
  input  logic [7:0]               m1_write_data,
  input  logic                     m1_read,
  input  logic                     m1_write,
  output logic                     m1_gnt,
  output logic [7:0]               m1_read_data,
  output logic                     m1_rdvalid,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  input  logic [7:0]               read_data,
  output logic [1:0]               O_owner,
  output logic [7:0]               O_forced_cnt,
  output logic                     O_dropped
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  typedef struct packed {
    logic                     req;
    logic                     rd;
    logic                     wr;
    logic [7:0]               addr;
    logic [pBYTECNT_SIZE-1:0] bc;
    logic [7:0]               wd;
  } mst_t;

  state_t                   state_q, state_d;
  mst_t                     m0_q, m0_d, m1_q, m1_d;
  logic [1:0]               drain_cnt_q, drain_cnt_d;
  logic [7:0]               wait_cnt_q, wait_cnt_d;
  logic [7:0]               forced_cnt_q, forced_cnt_d;
  logic                     dropped_q, dropped_d;
  logic [7:0]               reg_address_q, reg_address_d;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q, reg_bytecnt_d;
  logic [7:0]               write_data_q, write_data_d;
  logic                     reg_read_q, reg_read_d;
  logic                     reg_write_q, reg_write_d;
  logic                     rd_owner_q, rd_owner_d;
  logic                     fwd0, fwd1, starve;
  logic                     rd_vld, rd_own;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    m0_d          = {m0_req, m0_read, m0_write, m0_address, m0_bytecnt, m0_write_data};
    m1_d          = {m1_req, m1_read, m1_write, m1_address, m1_bytecnt, m1_write_data};
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    forced_cnt_d  = forced_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    reg_address_d = '0;
    reg_bytecnt_d = '0;
    write_data_d  = '0;
    starve        = (wait_cnt_q >= 8'(pMAX_WAIT));
    // Strobes pass only while the owner is still holding its request.
    fwd0          = (state_q == OWN0) && m0_q.req;
    fwd1          = (state_q == OWN1) && m1_q.req;

    unique case (state_q)
      IDLE: begin
        if (m0_q.req && m1_q.req) begin
          if (starve) begin
            state_d = OWN1;
            if (forced_cnt_q != 8'hFF) forced_cnt_d = forced_cnt_q + 8'd1;
          end else begin
            state_d = OWN0;
          end
        end else if (m0_q.req) begin
          state_d = OWN0;
        end else if (m1_q.req) begin
          state_d = OWN1;
        end
      end
      OWN0: if (!m0_q.req) begin state_d = DRAIN; drain_cnt_d = '0; end
      OWN1: if (!m1_q.req) begin state_d = DRAIN; drain_cnt_d = '0; end
      DRAIN: begin
        if (drain_cnt_q == 2'(pREAD_LATENCY)) state_d = IDLE;
        else drain_cnt_d = drain_cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN1 && state_q != OWN1) wait_cnt_d = '0;
    else if (m1_q.req && state_q != OWN1 && wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;

    if (state_d == OWN0) begin
      reg_address_d = m0_q.addr; reg_bytecnt_d = m0_q.bc; write_data_d = m0_q.wd;
    end else if (state_d == OWN1) begin
      reg_address_d = m1_q.addr; reg_bytecnt_d = m1_q.bc; write_data_d = m1_q.wd;
    end

    reg_read_d  = (fwd0 && m0_q.rd) || (fwd1 && m1_q.rd);
    reg_write_d = (fwd0 && m0_q.wr) || (fwd1 && m1_q.wr);
    rd_owner_d  = fwd1;
    dropped_d   = ((m0_q.rd || m0_q.wr) && !fwd0) || ((m1_q.rd || m1_q.wr) && !fwd1);
  end

  always_ff @(posedge usb_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (reset_i) begin
      state_q       <= IDLE;
      m0_q          <= '0;
      m1_q          <= '0;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      forced_cnt_q  <= '0;
      dropped_q     <= 1'b0;
      reg_address_q <= '0;
      reg_bytecnt_q <= '0;
      write_data_q  <= '0;
      reg_read_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      rd_owner_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      m0_q          <= m0_d;
      m1_q          <= m1_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      forced_cnt_q  <= forced_cnt_d;
      dropped_q     <= dropped_d;
      reg_address_q <= reg_address_d;
      reg_bytecnt_q <= reg_bytecnt_d;
      write_data_q  <= write_data_d;
      reg_read_q    <= reg_read_d;
      reg_write_q   <= reg_write_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

  // Tags each slave-side read with its issuer until the slave data is valid.
  if (pREAD_LATENCY == 0) begin : g_lat0
    assign rd_vld = reg_read_q;
    assign rd_own = rd_owner_q;
  end else begin : g_lat1
    logic pipe_vld_q, pipe_own_q;
    always_ff @(posedge usb_clk) begin
      if (reset_i) begin
        pipe_vld_q <= 1'b0;
        pipe_own_q <= 1'b0;
      end else begin
        pipe_vld_q <= reg_read_q;
        pipe_own_q <= rd_owner_q;
      end
    end
    assign rd_vld = pipe_vld_q;
    assign rd_own = pipe_own_q;
  end

  assign m0_gnt        = (state_q == OWN0);
  assign m1_gnt        = (state_q == OWN1);
  assign O_owner       = {state_q == OWN1, state_q == OWN0};
  assign reg_addrvalid = (state_q == OWN0) || (state_q == OWN1);
  assign reg_address   = reg_address_q;
  assign reg_bytecnt   = reg_bytecnt_q;
  assign write_data    = write_data_q;
  assign reg_read      = reg_read_q;
  assign reg_write     = reg_write_q;
  assign O_forced_cnt  = forced_cnt_q;
  assign O_dropped     = dropped_q;
  assign m0_rdvalid    = rd_vld && !rd_own;
  assign m1_rdvalid    = rd_vld && rd_own;
  assign m0_read_data  = m0_rdvalid ? read_data : 8'h00;
  assign m1_read_data  = m1_rdvalid ? read_data : 8'h00;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a counter-based reference of the arbitration rules.
module tb_reg_bus_arbiter;
  localparam int L    = 1;
  localparam int MAXW = 4;
  localparam int BC   = 7;

  logic          usb_clk, reset_i;
  logic          m0_req, m0_read, m0_write, m1_req, m1_read, m1_write;
  logic [7:0]    m0_address, m0_write_data, m1_address, m1_write_data, read_data;
  logic [BC-1:0] m0_bytecnt, m1_bytecnt;
  logic          m0_gnt, m1_gnt, m0_rdvalid, m1_rdvalid;
  logic [7:0]    m0_read_data, m1_read_data, reg_address, write_data, O_forced_cnt;
  logic [BC-1:0] reg_bytecnt;
  logic          reg_read, reg_write, reg_addrvalid, O_dropped;
  logic [1:0]    O_owner;

  reg_bus_arbiter #(.pBYTECNT_SIZE(BC), .pREAD_LATENCY(L), .pMAX_WAIT(MAXW)) dut (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .m0_req(m0_req), .m0_address(m0_address), .m0_bytecnt(m0_bytecnt),
    .m0_write_data(m0_write_data), .m0_read(m0_read), .m0_write(m0_write),
    .m0_gnt(m0_gnt), .m0_read_data(m0_read_data), .m0_rdvalid(m0_rdvalid),
    .m1_req(m1_req), .m1_address(m1_address), .m1_bytecnt(m1_bytecnt),
    .m1_write_data(m1_write_data), .m1_read(m1_read), .m1_write(m1_write),
    .m1_gnt(m1_gnt), .m1_read_data(m1_read_data), .m1_rdvalid(m1_rdvalid),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .read_data(read_data), .O_owner(O_owner), .O_forced_cnt(O_forced_cnt),
    .O_dropped(O_dropped)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  logic [56:0] outs;
  assign outs = {m0_gnt, m1_gnt, O_owner, reg_read, reg_write, reg_addrvalid, reg_address,
                 reg_bytecnt, write_data, m0_rdvalid, m1_rdvalid, m0_read_data,
                 m1_read_data, O_forced_cnt, O_dropped};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Reference: owner 0 none / 1 m0 / 2 m1, drain = idle cycles still owed.
  typedef struct packed {
    bit req; bit rd; bit wr; bit [7:0] addr; bit [BC-1:0] bc; bit [7:0] wd;
  } mst_s;

  mst_s          seen0, seen1;
  int            m_owner, m_drain, m_wait, m_forced;
  bit            e_rd, e_wr, e_drop;
  bit [7:0]      e_addr, e_wd;
  bit [BC-1:0]   e_bc;
  bit            hv[0:L];
  bit            hw[0:L];

  task automatic model_step();
    mst_s s0, s1;
    bit   f0, f1, new_rd;
    int   nown;
    if (reset_i) begin
      m_owner = 0; m_drain = 0; m_wait = 0; m_forced = 0;
      e_rd = 0; e_wr = 0; e_drop = 0; e_addr = 0; e_wd = 0; e_bc = 0;
      for (int i = 0; i <= L; i++) begin hv[i] = 0; hw[i] = 0; end
      seen0 = '0; seen1 = '0;
      return;
    end
    s0 = seen0; s1 = seen1;
    f0 = (m_owner == 1) && s0.req;
    f1 = (m_owner == 2) && s1.req;
    e_wr   = (f0 && s0.wr) || (f1 && s1.wr);
    new_rd = (f0 && s0.rd) || (f1 && s1.rd);
    e_drop = ((s0.rd || s0.wr) && !f0) || ((s1.rd || s1.wr) && !f1);
    nown = m_owner;
    if (m_owner == 0 && m_drain == 0) begin
      if (s0.req && s1.req) begin
        if (m_wait >= MAXW) begin
          nown = 2;
          if (m_forced < 255) m_forced++;
        end else nown = 1;
      end else if (s0.req) nown = 1;
      else if (s1.req) nown = 2;
    end else if (m_owner != 0 && !((m_owner == 1) ? s0.req : s1.req)) begin
      nown = 0;
      m_drain = L + 1;
    end else if (m_drain > 0) begin
      m_drain--;
    end
    if (nown == 2 && m_owner != 2) m_wait = 0;
    else if (s1.req && m_owner != 2 && m_wait < 255) m_wait++;
    e_addr = (nown == 1) ? s0.addr : (nown == 2) ? s1.addr : 8'h00;
    e_bc   = (nown == 1) ? s0.bc   : (nown == 2) ? s1.bc   : '0;
    e_wd   = (nown == 1) ? s0.wd   : (nown == 2) ? s1.wd   : 8'h00;
    for (int i = L; i > 0; i--) begin hv[i] = hv[i-1]; hw[i] = hw[i-1]; end
    hv[0] = new_rd; hw[0] = f1;
    e_rd = new_rd;
    m_owner = nown;
    seen0 = {m0_req, m0_read, m0_write, m0_address, m0_bytecnt, m0_write_data};
    seen1 = {m1_req, m1_read, m1_write, m1_address, m1_bytecnt, m1_write_data};
  endtask

  function automatic logic [56:0] model_vec();
    bit rv0, rv1;
    logic [1:0] own;
    rv0 = hv[L] && !hw[L];
    rv1 = hv[L] && hw[L];
    own = (m_owner == 2) ? 2'b10 : (m_owner == 1) ? 2'b01 : 2'b00;
    return {m_owner == 1, m_owner == 2, own, e_rd, e_wr, m_owner != 0, e_addr, e_bc, e_wd,
            rv0, rv1, rv0 ? read_data : 8'h00, rv1 ? read_data : 8'h00, 8'(m_forced), e_drop};
  endfunction

  task automatic cycle();
    @(posedge usb_clk);
    model_step();
    #1;
    check("cycle", 64'(outs), 64'(model_vec()));
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 30; i++) begin
      if (m0_gnt || m1_gnt) return;
      cycle();
    end
    check("gnt_timeout", 64'(m0_gnt | m1_gnt), 64'd1);
  endtask

  int cnt;

  initial begin
    reset_i = 1; read_data = 0;
    m0_req = 0; m0_read = 0; m0_write = 0; m0_address = 0; m0_bytecnt = 0; m0_write_data = 0;
    m1_req = 0; m1_read = 0; m1_write = 0; m1_address = 0; m1_bytecnt = 0; m1_write_data = 0;
    repeat (2) cycle();
    check("rst_outs", 64'(outs), 64'd0);
    reset_i = 0;
    cycle();

    // m0 alone writes 0xA5 to 0x05
    m0_req = 1; cycle(); wait_gnt();
    m0_write = 1; m0_address = 8'h05; m0_write_data = 8'hA5; m0_bytecnt = 0;
    cycle();
    m0_write = 0;
    cycle();
    check("wr_strobe", 64'(reg_write), 64'd1);
    check("wr_addr", 64'(reg_address), 64'h05);
    check("wr_data", 64'(write_data), 64'hA5);
    check("wr_owner", 64'(O_owner), 64'd1);
    cycle();
    check("wr_once", 64'(reg_write), 64'd0);
    m0_req = 0; repeat (5) cycle();

    // m1 reads 0x01, slave returns 0x01
    m1_req = 1; read_data = 8'h01; cycle(); wait_gnt();
    m1_read = 1; m1_address = 8'h01;
    cycle();
    m1_read = 0;
    cycle(); cycle();
    check("rd_valid1", 64'(m1_rdvalid), 64'd1);
    check("rd_data1", 64'(m1_read_data), 64'h01);
    check("rd_valid0", 64'(m0_rdvalid), 64'd0);
    m1_req = 0; repeat (5) cycle();

    // contention, starve flag clear
    m0_req = 1; m1_req = 1; cycle(); wait_gnt();
    check("cont_m0", 64'({m0_gnt, m1_gnt}), 64'b10);
    cycle();
    m0_req = 0;
    repeat (4) cycle();
    check("cont_wait", 64'(m1_gnt), 64'd0);
    cycle();
    check("cont_m1", 64'(m1_gnt), 64'd1);
    check("cont_forced", 64'(O_forced_cnt), 64'd0);
    m1_req = 0; repeat (5) cycle();

    // starvation: m0 drops and re-raises while m1 waits
    m0_req = 1; cycle(); wait_gnt();
    m1_req = 1; repeat (8) cycle();
    m0_req = 0; cycle();
    m0_req = 1; cycle();
    wait_gnt();
    check("starve_m1", 64'({m0_gnt, m1_gnt}), 64'b01);
    check("starve_forced", 64'(O_forced_cnt), 64'd1);
    check("starve_wait", 64'(dut.wait_cnt_q), 64'd0);
    cycle();
    m1_req = 0; repeat (5) cycle();
    m0_req = 0; repeat (5) cycle();

    // read on last granted cycle is still routed during DRAIN
    m0_req = 1; cycle(); wait_gnt();
    m0_read = 1; m0_address = 8'h02; read_data = 8'h5A;
    cycle();
    m0_read = 0; m0_req = 0; m1_req = 1;
    cycle(); cycle();
    check("drain_rdv", 64'(m0_rdvalid), 64'd1);
    check("drain_rdd", 64'(m0_read_data), 64'h5A);
    check("drain_gnt1", 64'(m1_gnt), 64'd0);
    cnt = 0;
    while (!m1_gnt && cnt < 20) begin cycle(); cnt++; end
    check("drain_lat", 64'(cnt), 64'd3);
    m1_req = 0; repeat (5) cycle();

    // non-owner strobe dropped, then reset with a read in flight
    m0_req = 1; cycle(); wait_gnt();
    m1_write = 1;
    cycle();
    m1_write = 0;
    cycle();
    check("drop_wr", 64'(reg_write), 64'd0);
    check("drop_pulse", 64'(O_dropped), 64'd1);
    cycle();
    check("drop_once", 64'(O_dropped), 64'd0);
    m0_read = 1; cycle();
    m0_read = 0; cycle();
    reset_i = 1; cycle();
    check("rst_mid", 64'(outs), 64'd0);
    m0_req = 0; cycle();
    reset_i = 0; repeat (3) cycle();

    // random traffic
    for (int t = 0; t < 1500; t++) begin
      if (!m0_req) m0_req = ($urandom % 4 == 0); else if ($urandom % 8 == 0) m0_req = 0;
      if (!m1_req) m1_req = ($urandom % 4 == 0); else if ($urandom % 6 == 0) m1_req = 0;
      m0_read = ($urandom % 3 == 0);  m0_write = ($urandom % 3 == 0);
      m1_read = ($urandom % 3 == 0);  m1_write = ($urandom % 3 == 0);
      m0_address = 8'($urandom); m0_bytecnt = BC'($urandom); m0_write_data = 8'($urandom);
      m1_address = 8'($urandom); m1_bytecnt = BC'($urandom); m1_write_data = 8'($urandom);
      read_data = 8'($urandom);
      reset_i = ($urandom % 300 == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
